// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
//
// Bus-side memory slave answering single-word accesses from cache controllers.
// Block fills and write-backs arrive as a series of word accesses. Each access
// is served after a fixed, programmable latency, and the completion flag is held
// until the master withdraws its enable.
//
// Optional feature (compile-time macro MAIN_MEMORY_ACCESS_COUNTERS_EN):
//   adds free-running 32-bit completed-read / completed-write counters.
//
// Parameters
//   ADDRESS_WIDTH : word address width (array depth = 2**ADDRESS_WIDTH)
//   DATA_WIDTH    : word width
//   LATENCY       : cycles from the accepting edge to functionComplete (1..15)
//
// Ports
//   clock             in   rising-edge clock
//   reset             in   asynchronous, active-high reset
//   address           in   word address from the bus master
//   dataOut           in   write data from the bus master
//   dataIn            out  read data to the bus master (registered)
//   readEnabled       in   read request level, held until completion is seen
//   writeEnabled      in   write request level, held until completion is seen
//   functionComplete  out  access done, held while the request stays high
//   readCount         out  completed reads  (only with the counters macro)
//   writeCount        out  completed writes (only with the counters macro)
// -----------------------------------------------------------------------------
module main_memory_responder #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int LATENCY       = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    dataOut,
    output logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     readEnabled,
    input  logic                     writeEnabled,
    output logic                     functionComplete
`ifdef MAIN_MEMORY_ACCESS_COUNTERS_EN
    ,
    output logic [31:0]              readCount,
    output logic [31:0]              writeCount
`endif
);

    // The latency counter is 4 bits wide, so only 1..15 can be represented.
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "main_memory_responder: LATENCY=%0d outside 1..15", LATENCY);
    end

    localparam logic [3:0] LOAD_VALUE = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    state_t                   state_r, state_n;
    logic [3:0]               count_r, count_n;
    logic                     fc_r, fc_n;
    logic [ADDRESS_WIDTH-1:0] addr_r, addr_n;
    logic [DATA_WIDTH-1:0]    data_r, data_n;
    logic                     op_write_r, op_write_n;
    logic [DATA_WIDTH-1:0]    data_in_r;
    logic                     mem_we_s;
    logic                     mem_re_s;
    logic                     req_active_s;

    // Storage array; intentionally has no reset.
    logic [DATA_WIDTH-1:0]    mem_r [0:(2**ADDRESS_WIDTH)-1];

    // Next-state and control decode for the access FSM.
    always_comb begin
        state_n    = state_r;
        count_n    = count_r;
        fc_n       = fc_r;
        addr_n     = addr_r;
        data_n     = data_r;
        op_write_n = op_write_r;
        mem_we_s   = 1'b0;
        mem_re_s   = 1'b0;
        // Only the enable of the operation that was accepted keeps it alive.
        req_active_s = op_write_r ? writeEnabled : readEnabled;

        case (state_r)
            ST_IDLE: begin
                fc_n = 1'b0;
                if (readEnabled || writeEnabled) begin
                    addr_n     = address;
                    data_n     = dataOut;
                    op_write_n = writeEnabled;   // write wins when both are high
                    count_n    = LOAD_VALUE;
                    state_n    = ST_ACCESS;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!req_active_s) begin
                    // Abort: master withdrew before completion, nothing is touched.
                    count_n = 4'd0;
                    fc_n    = 1'b0;
                    state_n = ST_IDLE;
                end else if (count_r == 4'd0) begin
                    if (op_write_r) begin
                        mem_we_s = 1'b1;
                    end else begin
                        mem_re_s = 1'b1;
                    end
                    fc_n    = 1'b1;
                    state_n = ST_COMPLETE;
                end else begin
                    count_n = count_r - 4'd1;
                    state_n = ST_ACCESS;
                end
            end
            ST_COMPLETE: begin
                if (!readEnabled && !writeEnabled) begin
                    fc_n    = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    fc_n    = 1'b1;
                    state_n = ST_COMPLETE;
                end
            end
            default: begin
                fc_n    = 1'b0;
                count_n = 4'd0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter, completion flag and latched request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= 4'd0;
            fc_r       <= 1'b0;
            addr_r     <= '0;
            data_r     <= '0;
            op_write_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            count_r    <= count_n;
            fc_r       <= fc_n;
            addr_r     <= addr_n;
            data_r     <= data_n;
            op_write_r <= op_write_n;
        end
    end

    // Array write port; fires on the same edge functionComplete rises.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= data_r;
        end
    end

    // Registered read data; held stable outside completing reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_in_r <= '0;
        end else if (mem_re_s) begin
            data_in_r <= mem_r[addr_r];
        end else begin
            data_in_r <= data_in_r;
        end
    end

    assign dataIn           = data_in_r;
    assign functionComplete = fc_r;

`ifdef MAIN_MEMORY_ACCESS_COUNTERS_EN
    logic [31:0] read_count_r;
    logic [31:0] write_count_r;

    // Completed-access counters; aborted accesses never strobe these enables.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_count_r  <= 32'd0;
            write_count_r <= 32'd0;
        end else begin
            if (mem_re_s) begin
                read_count_r <= read_count_r + 32'd1;
            end
            if (mem_we_s) begin
                write_count_r <= write_count_r + 32'd1;
            end
        end
    end

    assign readCount  = read_count_r;
    assign writeCount = write_count_r;
`endif

endmodule
